rom_dl_arbiter: RTL and testbench
=================================

// Module: rom_dl_arbiter
// PURPOSE
//   Sole owner of the single-port game program ROM/RAM in the FoodFight core.
//   Sequences HPS ioctl downloads into the memory, arbitrating against CPU
//   reads. Generates ioctl_wait back-pressure and a clean game reset around
//   each download. Flags the ROM valid once a complete image is loaded.
// PARAMETERS
//   AW       16       memory address width (bytes)
//   MEM_LAT  2        memory read latency, cycles from mem_en to mem_rdata valid (>=1)
//   ROM_SIZE 'hC000   image size in bytes; download writes at addr >= ROM_SIZE are dropped
//   DL_INDEX 0        ioctl_index value accepted; other indexes are ignored entirely
//   RST_HOLD 16       cycles game_reset stays high after a download completes
// PORTS
//   clk_sys        in   1   system clock; all logic on rising edge
//   reset          in   1   asynchronous, active-high
//   ioctl_download in   1   HPS download active
//   ioctl_index    in   8   download target index
//   ioctl_wr       in   1   1-cycle byte strobe; only issued by HPS while ioctl_wait=0
//   ioctl_addr     in   25  byte address
//   ioctl_dout     in   8   byte data
//   ioctl_wait     out  1   back-pressure to HPS
//   cpu_req        in   1   read request; CPU holds it high until cpu_ack
//   cpu_addr       in   AW  read address, stable while cpu_req is high
//   cpu_rdata      out  8   read data, valid while cpu_ack=1
//   cpu_ack        out  1   1-cycle read-complete pulse
//   mem_en         out  1   memory access strobe, 1 cycle per access
//   mem_we         out  1   write qualifier, valid with mem_en
//   mem_addr       out  AW  memory address
//   mem_wdata      out  8   memory write data
//   mem_rdata      in   8   memory read data
//   dl_busy        out  1   download session in progress
//   dl_done        out  1   1-cycle pulse at end of a session
//   dl_count       out  AW+1 bytes accepted in the current/last session, saturating
//   rom_valid      out  1   last session delivered >= ROM_SIZE bytes
//   game_reset     out  1   reset to the game core
// BEHAVIOUR
//   Reset values: all outputs 0 except game_reset=1. Pending write and read are discarded.
//   Reset asserted mid-access aborts the access; rom_valid is cleared.
//   dl_sel = ioctl_download && ioctl_index==DL_INDEX.
//   Session start: dl_sel rising while dl_busy=0.
//     Next cycle dl_busy=1, game_reset=1, dl_count=0.
//   Write capture: ioctl_wr && dl_sel && ioctl_addr<ROM_SIZE.
//     Latch ioctl_addr[AW-1:0] and data, set wr_pend, ioctl_wait=1 from the next cycle.
//     dl_count += 1, saturating at all-ones.
//     Non-matching or out-of-range strobes: dropped, no wait, not counted.
//   FSM states IDLE, WR, RD, RDW:
//     IDLE: if wr_pend -> WR; elif cpu_req && !cpu_ack && !game_reset -> RD. Writes win ties.
//     WR (1 cycle): mem_en=1, mem_we=1, held addr/data. Clear wr_pend; ioctl_wait=0 next cycle -> IDLE.
//     RD (1 cycle): mem_en=1, mem_we=0, mem_addr=cpu_addr -> RDW.
//     RDW: wait MEM_LAT cycles; capture mem_rdata on the edge closing cycle RD+MEM_LAT.
//       cpu_ack=1 and cpu_rdata valid next cycle -> IDLE.
//   Uncontended read: cpu_req high in cycle 0 -> mem_en in cycle 1 -> cpu_ack in cycle 2+MEM_LAT.
//   Write stall bound: a write captured during RD/RDW completes within MEM_LAT+3 cycles.
//   A read is never aborted by a write.
//   cpu_req while game_reset=1: not served, no ack.
//   Session end: dl_sel low while dl_busy=1; wait until wr_pend=0 and state=IDLE, then:
//     dl_busy=0, dl_done=1 for 1 cycle, rom_valid=(dl_count>=ROM_SIZE).
//     Load hold counter with RST_HOLD.
//   game_reset = !rom_valid || dl_busy || hold!=0 (registered).
//     Falls exactly RST_HOLD cycles after dl_done if rom_valid=1.
//   New session start while hold counter is running: the counter is cleared.
//   mem_en/mem_we are never both asserted in back-to-back cycles for the same write.
//     Exactly one mem write per accepted byte.
// TESTING
//   Reset, idle: game_reset=1, ioctl_wait=0, mem_en=0, rom_valid=0; cpu_req=1 -> no ack.
//   Download 0xC000 bytes, index 0, addr=data=addr[7:0]:
//     -> 0xC000 mem writes; ioctl_wait=1 one cycle after each strobe;
//     -> dl_done=1, rom_valid=1, dl_count=0xC000; game_reset falls 16 cycles after dl_done.
//   Post-load read, cpu_addr=0x1234 -> mem_en in cycle 1, cpu_ack in cycle 4, cpu_rdata=0x34.
//   Strobes with index 1, or addr 0xC000 -> no mem write, no wait, dl_count unchanged.
//   Short download of 0x100 bytes -> rom_valid=0, game_reset stays 1, cpu_req unserved.
//   ioctl_wr arriving in the RD cycle of a read:
//     -> read acks with correct data; write issues in the following IDLE->WR, within MEM_LAT+3 cycles.
//   Reset pulse mid-download -> all outputs to reset values; a fresh session restarts dl_count at 0.

Source files
------------

// File: rtl/rom_dl_arbiter.sv
// Owns the single-port program memory: serialises HPS download writes against CPU reads,
// generates ioctl_wait back-pressure and holds the game in reset around each download.
module rom_dl_arbiter #(
    parameter int unsigned AW       = 16,
    parameter int unsigned MEM_LAT  = 2,
    parameter int unsigned ROM_SIZE = 'hC000,
    parameter int unsigned DL_INDEX = 0,
    parameter int unsigned RST_HOLD = 16
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          dl_busy,
    output logic          dl_done,
    output logic [AW:0]   dl_count,
    output logic          rom_valid,
    output logic          game_reset
);

    localparam int unsigned HW = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
    localparam int unsigned LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [24:0] RomSizeA = 25'(ROM_SIZE);
    localparam logic [AW:0] RomSizeC = (AW + 1)'(ROM_SIZE);
    localparam logic [7:0]  IdxW     = 8'(DL_INDEX);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StRdw} state_e;

    state_e        state_q, state_d;
    logic          dl_sel, wr_cap, sess_start, sess_end;
    logic          dl_sel_q, wr_pend_q, wr_pend_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          dl_busy_q, dl_busy_d, dl_done_q, dl_done_d;
    logic [AW:0]   dl_count_q, dl_count_d;
    logic          rom_valid_q, rom_valid_d, game_reset_q, game_reset_d;

    assign dl_sel     = ioctl_download && (ioctl_index == IdxW);
    // A strobe while a byte is still pending is not accepted, so each counted byte is written once.
    assign wr_cap     = ioctl_wr && dl_sel && (ioctl_addr < RomSizeA) && !wr_pend_q;
    assign sess_start = dl_sel && !dl_sel_q && !dl_busy_q;
    assign sess_end   = dl_busy_q && !dl_sel && !wr_pend_q && (state_q == StIdle);

    always_comb begin
        state_d     = state_q;
        wr_pend_d   = wr_pend_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        lat_d       = lat_q;
        hold_d      = hold_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = 1'b0;
        dl_busy_d   = dl_busy_q;
        dl_done_d   = 1'b0;
        dl_count_d  = dl_count_q;
        rom_valid_d = rom_valid_q;

        unique case (state_q)
            StIdle: begin
                if (wr_pend_q) begin
                    state_d     = StWr;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_addr_q;
                    mem_wdata_d = wr_data_q;
                end else if (cpu_req && !cpu_ack_q && !game_reset_q) begin
                    state_d    = StRd;
                    mem_en_d   = 1'b1;
                    mem_addr_d = cpu_addr;
                end
            end
            StWr: begin
                wr_pend_d = 1'b0;
                state_d   = StIdle;
            end
            StRd: begin
                lat_d   = LW'(MEM_LAT - 1);
                state_d = StRdw;
            end
            StRdw: begin
                if (lat_q == '0) begin
                    cpu_rdata_d = mem_rdata;
                    cpu_ack_d   = 1'b1;
                    state_d     = StIdle;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (hold_q != '0) hold_d = hold_q - HW'(1);

        if (sess_start) begin
            dl_busy_d  = 1'b1;
            dl_count_d = '0;
            hold_d     = '0;
        end
        if (sess_end) begin
            dl_busy_d   = 1'b0;
            dl_done_d   = 1'b1;
            rom_valid_d = (dl_count_q >= RomSizeC);
            hold_d      = HW'(RST_HOLD);
        end

        if (wr_cap) begin
            wr_pend_d = 1'b1;
            wr_addr_d = ioctl_addr[AW-1:0];
            wr_data_d = ioctl_dout;
            if (dl_count_d != '1) dl_count_d = dl_count_d + {{AW{1'b0}}, 1'b1};
        end

        game_reset_d = !rom_valid_d || dl_busy_d || (hold_d != '0);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            dl_sel_q     <= 1'b0;
            wr_pend_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            lat_q        <= '0;
            hold_q       <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            dl_busy_q    <= 1'b0;
            dl_done_q    <= 1'b0;
            dl_count_q   <= '0;
            rom_valid_q  <= 1'b0;
            game_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            dl_sel_q     <= dl_sel;
            wr_pend_q    <= wr_pend_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            lat_q        <= lat_d;
            hold_q       <= hold_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            dl_busy_q    <= dl_busy_d;
            dl_done_q    <= dl_done_d;
            dl_count_q   <= dl_count_d;
            rom_valid_q  <= rom_valid_d;
            game_reset_q <= game_reset_d;
        end
    end

    assign ioctl_wait = wr_pend_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign dl_busy    = dl_busy_q;
    assign dl_done    = dl_done_q;
    assign dl_count   = dl_count_q;
    assign rom_valid  = rom_valid_q;
    assign game_reset = game_reset_q;

endmodule

// File: tb/tb_rom_dl_arbiter.sv
// Bench for rom_dl_arbiter: random download data and read addresses against a byte-array model
// of the ROM image, with a latency-MEM_LAT memory attached to the memory port.
module tb_rom_dl_arbiter;

    localparam int unsigned AW      = 16;
    localparam int unsigned MemLat  = 2;
    localparam int unsigned RomSize = 'h1400;
    localparam int unsigned RstHold = 16;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ioctl_download, ioctl_wr, ioctl_wait;
    logic [7:0]    ioctl_index, ioctl_dout;
    logic [24:0]   ioctl_addr;
    logic          cpu_req, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata;
    logic          dl_busy, dl_done, rom_valid, game_reset;
    logic [AW:0]   dl_count;

    rom_dl_arbiter #(
        .AW(AW), .MEM_LAT(MemLat), .ROM_SIZE(RomSize), .DL_INDEX(0), .RST_HOLD(RstHold)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .dl_busy(dl_busy), .dl_done(dl_done), .dl_count(dl_count), .rom_valid(rom_valid),
        .game_reset(game_reset)
    );

    always #5 clk_sys = ~clk_sys;

    int unsigned n_cmp = 0, n_bad = 0;
    int unsigned cyc = 0;
    int unsigned wr_seen = 0, wr_bad = 0, b2b_bad = 0, rd_seen = 0, ack_seen = 0;
    int unsigned last_wr_cyc = 0, wait_bad = 0, timeouts = 0, model_cnt = 0;
    logic [23:0] exp_q [$];
    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [7:0]  d1, d2;
    logic        v1 = 1'b0, v2 = 1'b0, prev_we = 1'b0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Memory model and write monitor, sampled on the falling edge.
    always @(negedge clk_sys) begin
        if (mem_en && mem_we) begin
            wr_seen <= wr_seen + 1;
            if (exp_q.size() == 0 || exp_q[0] !== {mem_addr, mem_wdata}) wr_bad <= wr_bad + 1;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            mem[mem_addr] <= mem_wdata;
            last_wr_cyc   <= cyc;
        end
        if (mem_en && mem_we && prev_we) b2b_bad <= b2b_bad + 1;
        prev_we <= mem_en && mem_we;
        if (mem_en && !mem_we) rd_seen <= rd_seen + 1;
        if (cpu_ack) ack_seen <= ack_seen + 1;
        mem_rdata <= v2 ? d2 : 8'($urandom);
        d2 <= d1;
        v2 <= v1;
        d1 <= mem[mem_addr];
        v1 <= mem_en && !mem_we;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        int n;
        bit acc;
        n = 0;
        while (ioctl_wait && n < 50) begin step(); n++; end
        if (n == 50) timeouts++;
        repeat ($urandom_range(0, 2)) step();
        acc = ioctl_download && idx == 8'd0 && a < 25'(RomSize);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        if (acc) begin
            exp_q.push_back({a[15:0], d});
            ref_mem[a[15:0]] = d;
            model_cnt++;
        end
        step();
        ioctl_wr = 1'b0;
        if (ioctl_wait !== acc) wait_bad++;
    endtask

    task automatic do_read(input logic [15:0] a);
        int n;
        cpu_addr = a;
        cpu_req  = 1'b1;
        step();
        check("rd_issue", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, a});
        n = 1;
        while (!cpu_ack && n < 20) begin step(); n++; end
        check("rd_latency", n, 2 + MemLat);
        check("rd_data", cpu_rdata, ref_mem[a]);
        cpu_req = 1'b0;
        step();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!dl_done && n < 100) begin step(); n++; end
        check(tag, n < 100, 1);
    endtask

    initial begin
        int unsigned rc, sc, ac;
        logic [7:0]  old5, d5;
        logic [24:0] junk;

        reset = 1'b1;
        ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0; ioctl_addr = 0; ioctl_dout = 0;
        cpu_req = 1'b1; cpu_addr = 16'h0010;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_game_reset", game_reset, 1);
        check("rst_outputs", {ioctl_wait, mem_en, rom_valid, dl_busy, dl_done, cpu_ack}, 0);
        check("rst_dl_count", dl_count, 0);
        repeat (10) step();
        check("rst_no_read", {rd_seen, ack_seen}, 0);
        cpu_req = 1'b0;

        // Full image with random data and dropped out-of-range strobes mixed in.
        ioctl_download = 1'b1; ioctl_index = 0; model_cnt = 0;
        step();
        check("start_busy", {dl_busy, game_reset}, 2'b11);
        strobe(8'd0, 25'hC000, 8'hAA);
        strobe(8'd0, 25'(RomSize), 8'h55);
        for (int a = 0; a < int'(RomSize); a++) begin
            if ($urandom_range(0, 7) == 0) begin
                junk = 25'(RomSize + $urandom_range(0, 'h10000));
                strobe(8'd0, junk, 8'($urandom));
            end
            strobe(8'd0, 25'(a), 8'($urandom));
        end
        ioctl_download = 1'b0;
        wait_done("full_done");
        check("full_count", dl_count, model_cnt);
        check("full_valid", {rom_valid, dl_busy}, 2'b10);
        check("full_writes", wr_seen, RomSize);
        check("full_wr_order", wr_bad, 0);
        check("full_wait", wait_bad, 0);
        repeat (RstHold - 1) step();
        check("hold_still_reset", game_reset, 1);
        step();
        check("hold_release", game_reset, 0);

        for (int i = 0; i < 8; i++) begin
            if (i == 0) do_read(16'h1234);
            else do_read(16'($urandom_range(0, RomSize - 1)));
        end

        // A whole session on another index must be invisible.
        sc = wr_seen;
        ioctl_download = 1'b1; ioctl_index = 8'd1;
        step();
        for (int i = 0; i < 10; i++) strobe(8'd1, 25'($urandom_range(0, RomSize - 1)), 8'hEE);
        check("idx1_no_write", wr_seen, sc);
        check("idx1_state", {dl_busy, game_reset, ioctl_wait}, 0);
        check("idx1_count", dl_count, RomSize);
        ioctl_download = 1'b0; ioctl_index = 8'd0;
        step();

        // Strobe lands in the RD cycle of a read of the same byte.
        old5 = ref_mem[5];
        d5 = 8'($urandom);
        cpu_addr = 16'd5; cpu_req = 1'b1;
        step();
        check("col_rd_issue", {mem_en, mem_we}, 2'b10);
        sc = cyc;
        model_cnt = 1;
        exp_q.push_back({16'd5, d5});
        ioctl_download = 1'b1; ioctl_index = 0; ioctl_addr = 25'd5; ioctl_dout = d5;
        ioctl_wr = 1'b1;
        step();
        ioctl_wr = 1'b0;
        check("col_wait", ioctl_wait, 1);
        rc = 2;
        while (!cpu_ack && rc < 20) begin step(); rc++; end
        check("col_rd_latency", rc, 2 + MemLat);
        check("col_rd_old_data", cpu_rdata, old5);
        cpu_req = 1'b0;
        ref_mem[5] = d5;
        rc = 0;
        while (ioctl_wait && rc < 20) begin step(); rc++; end
        check("col_wr_bound", (last_wr_cyc > sc) && (last_wr_cyc - sc <= MemLat + 3), 1);

        // Short download: only 0x100 bytes.
        for (int a = 1; a < 'h100; a++) strobe(8'd0, 25'(a), 8'($urandom));
        ioctl_download = 1'b0;
        wait_done("short_done");
        check("short_count", dl_count, 'h100);
        check("short_valid", rom_valid, 0);
        rc = rd_seen; ac = ack_seen;
        cpu_req = 1'b1; cpu_addr = 16'h0020;
        repeat (30) step();
        check("short_game_reset", game_reset, 1);
        check("short_no_read", {rd_seen - rc, ack_seen - ac}, 0);
        cpu_req = 1'b0;

        // Asynchronous reset with a byte still pending.
        ioctl_download = 1'b1; model_cnt = 0;
        step();
        for (int a = 0; a < 20; a++) strobe(8'd0, 25'(a), 8'($urandom));
        check("mid_wait_before", ioctl_wait, 1);
        reset = 1'b1; ioctl_download = 1'b0;
        #1;
        check("mid_rst_outputs", {ioctl_wait, mem_en, rom_valid, dl_busy, dl_done, cpu_ack}, 0);
        check("mid_rst_game_reset", {game_reset, dl_count}, {1'b1, 17'd0});
        exp_q.delete();
        repeat (2) step();
        reset = 1'b0;
        step();
        ioctl_download = 1'b1; model_cnt = 0;
        step();
        check("fresh_start", {dl_busy, dl_count}, {1'b1, 17'd0});
        for (int a = 0; a < 'h30; a++) strobe(8'd0, 25'(a), 8'($urandom));
        ioctl_download = 1'b0;
        wait_done("fresh_done");
        check("fresh_count", dl_count, model_cnt);
        check("fresh_valid", rom_valid, 0);
        check("end_wr_order", wr_bad, 0);
        check("end_queue_empty", exp_q.size(), 0);
        check("end_no_b2b", b2b_bad, 0);
        check("end_wait", wait_bad, 0);
        check("end_timeouts", timeouts, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
